// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the operand-select stage and the iterative
// RV32M multiply/divide unit.
interface alu_muldiv_if #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 3
) ();
    logic                start;
    logic [OP_WIDTH-1:0] op;
    logic [WIDTH-1:0]    alu_src1;
    logic [WIDTH-1:0]    alu_src2;
    logic                flush;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    result;

    modport master (
        output start, op, alu_src1, alu_src2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, alu_src1, alu_src2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module alu_muldiv #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [OP_WIDTH-1:0] op_reg;
    logic [2*WIDTH-1:0]  acc_reg;
    logic [WIDTH-1:0]    opb_reg;
    logic                neg_reg;
    logic                fast_reg;
    logic [WIDTH-1:0]    fast_val_reg;
    logic [CW-1:0]       count_reg;
    logic [WIDTH-1:0]    result_reg;

    // ---------------- request decode (IDLE only) ----------------
    logic             accept;
    logic             in_is_div, in_a_signed, in_b_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_in;
    logic             div_zero, div_ovf, special;
    logic [WIDTH-1:0] div_fast_val;
    logic             fast_in;
    logic [WIDTH-1:0] fast_val_in;

    assign accept = (state_reg == S_IDLE) && bus.start && !bus.flush;

    always_comb begin
        in_is_div   = bus.op[2];
        in_a_signed = in_is_div ? ~bus.op[0] : (bus.op[1:0] == 2'd1 || bus.op[1:0] == 2'd2);
        in_b_signed = in_is_div ? ~bus.op[0] : (bus.op[1:0] == 2'd1);
        a_neg       = in_a_signed & bus.alu_src1[WIDTH-1];
        b_neg       = in_b_signed & bus.alu_src2[WIDTH-1];
        a_mag       = a_neg ? -bus.alu_src1 : bus.alu_src1;
        b_mag       = b_neg ? -bus.alu_src2 : bus.alu_src2;
        // REM follows the dividend sign; everything else takes the XOR of signs
        neg_in      = (in_is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = (bus.alu_src2 == '0);
        div_ovf     = in_is_div && in_a_signed &&
                      (bus.alu_src1 == INT_MIN) && (bus.alu_src2 == '1);
        special     = in_is_div && (div_zero || div_ovf);
        if (div_zero)
            div_fast_val = bus.op[1] ? bus.alu_src1 : '1;
        else
            div_fast_val = bus.op[1] ? '0 : INT_MIN;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] fm_a, fm_b, fm_prod;

    always_comb begin
        fm_a    = {{WIDTH{a_neg}}, bus.alu_src1};
        fm_b    = {{WIDTH{b_neg}}, bus.alu_src2};
        fm_prod = fm_a * fm_b;
        fast_in = special || !in_is_div;
        if (in_is_div)
            fast_val_in = div_fast_val;
        else if (bus.op[1:0] == 2'd0)
            fast_val_in = fm_prod[WIDTH-1:0];
        else
            fast_val_in = fm_prod[2*WIDTH-1:WIDTH];
    end
`else
    always_comb begin
        fast_in     = special;
        fast_val_in = div_fast_val;
    end
`endif

    // ---------------- iteration datapath ----------------
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rs;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        acc_hi   = acc_reg[2*WIDTH-1:WIDTH];
        acc_lo   = acc_reg[WIDTH-1:0];
        // multiply: hi holds partial product, lo shifts the multiplier out
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_lo[WIDTH-1:1]};
        // divide: hi is the partial remainder, lo shifts dividend out / quotient in
        div_rs   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = (div_rs >= {1'b0, opb_reg});
        div_diff = div_rs[WIDTH-1:0] - opb_reg;
        div_next = div_ge ? {div_diff, acc_lo[WIDTH-2:0], 1'b1}
                          : {div_rs[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
    end

    // ---------------- result formation ----------------
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed, rem_signed;
    logic [WIDTH-1:0]   calc_val, final_val;

    always_comb begin
        prod_signed = neg_reg ? -acc_reg : acc_reg;
        quo_signed  = neg_reg ? -acc_lo : acc_lo;
        rem_signed  = neg_reg ? -acc_hi : acc_hi;
        if (!op_reg[2])
            calc_val = (op_reg[1:0] == 2'd0) ? prod_signed[WIDTH-1:0]
                                             : prod_signed[2*WIDTH-1:WIDTH];
        else
            calc_val = op_reg[1] ? rem_signed : quo_signed;
        final_val = fast_reg ? fast_val_reg : calc_val;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept)
                    state_next = fast_in ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (bus.flush)
                    state_next = S_IDLE;
                else if (count_reg == '0)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy   = (state_reg == S_CALC);
        bus.done   = (state_reg == S_DONE) && !bus.flush;
        bus.result = bus.done ? final_val : result_reg;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg       <= '0;
            acc_reg      <= '0;
            opb_reg      <= '0;
            neg_reg      <= 1'b0;
            fast_reg     <= 1'b0;
            fast_val_reg <= '0;
            count_reg    <= '0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg       <= bus.op;
                        neg_reg      <= neg_in;
                        fast_reg     <= fast_in;
                        fast_val_reg <= fast_val_in;
                        count_reg    <= CW'(WIDTH - 1);
                        if (in_is_div) begin
                            acc_reg <= {{WIDTH{1'b0}}, a_mag};
                            opb_reg <= b_mag;
                        end else begin
                            acc_reg <= {{WIDTH{1'b0}}, b_mag};
                            opb_reg <= a_mag;
                        end
                    end
                end
                S_CALC: begin
                    acc_reg   <= op_reg[2] ? div_next : mul_next;
                    count_reg <= count_reg - 1'b1;
                end
                S_DONE: begin
                    if (!bus.flush)
                        result_reg <= final_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv: per-cycle model compare plus
// hand-computed literal expectations for results, latency and control paths.
module tb_alu_muldiv;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(W), .OP_WIDTH(3)) bus ();

    alu_muldiv #(.WIDTH(W), .OP_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [31:0] ref_val(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        q   = '0;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit f;
        f = (o >= 4) && ((b == 0) ||
            ((o == 4 || o == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
        f = f || (o < 4);
`endif
        return f;
    endfunction

    // model: one outstanding request, cycles left until its done cycle
    logic        m_pend = 1'b0;
    int          m_rem = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_last = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_last <= '0;
        end else if (m_pend) begin
            if (bus.flush)
                m_pend <= 1'b0;
            else if (m_rem == 0) begin
                m_last <= m_val;
                m_pend <= 1'b0;
            end else
                m_rem <= m_rem - 1;
        end else if (bus.start && !bus.flush) begin
            m_pend <= 1'b1;
            m_val  <= ref_val(bus.op, bus.alu_src1, bus.alu_src2);
            m_rem  <= is_fast(bus.op, bus.alu_src1, bus.alu_src2) ? 0 : W;
        end
    end

    always @(negedge clk) begin
        logic eb, ed;
        logic [31:0] er;
        if (bus.done) done_cnt++;
        if (bus.busy) busy_cnt++;
        if (chk_en) begin
            eb = m_pend && (m_rem > 0);
            ed = m_pend && (m_rem == 0) && !bus.flush;
            er = ed ? m_val : m_last;
            chk("cyc_busy", {31'b0, bus.busy}, {31'b0, eb});
            chk("cyc_done", {31'b0, bus.done}, {31'b0, ed});
            chk("cyc_result", bus.result, er);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat_exp, input string nm);
        int lat, d0, b0;
        d0 = done_cnt;
        b0 = busy_cnt;
        bus.op = o; bus.alu_src1 = a; bus.alu_src2 = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op = 3'($urandom);
        bus.alu_src1 = $urandom;
        bus.alu_src2 = $urandom;
        lat = 1;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, lat_exp);
        chk({nm, "_result"}, bus.result, e);
        tick();
        chk({nm, "_pulses"}, done_cnt - d0, 1);
        chk({nm, "_busy_cycles"}, busy_cnt - b0, lat_exp - 1);
        $display("op=%0d a=%h b=%h -> result=%h latency=%0d", o, a, b, e, lat);
    endtask

    initial begin
        int d0, lat;
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
        bus.alu_src1 = '0; bus.alu_src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        tick();

        do_op(3'd0, 32'd7, 32'd6, 32'h0000_002A, MUL_LAT, "mul_7x6");
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu");
        do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, "mulhsu");
        do_op(3'd0, 32'd3, 32'd5, 32'd15, MUL_LAT, "mul_3x5");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
        do_op(3'd4, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, "div_m100_m7");
        do_op(3'd6, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, "rem_m100_m7");
        do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
        do_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by_zero");
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
        do_op(3'd5, 32'd1000, 32'd3, 32'd333, 33, "divu_1000_3");

        // flush on the 10th CALC cycle
        d0 = done_cnt;
        bus.op = 3'd5; bus.alu_src1 = 32'd50; bus.alu_src2 = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_result", bus.result, 32'd333);
        repeat (40) tick();
        chk("flush_no_done", done_cnt - d0, 0);
        $display("flush mid-CALC: result held at %h", bus.result);
        do_op(3'd5, 32'd50, 32'd7, 32'd7, 33, "divu_after_flush");

        // flush during a fast-path DONE cycle suppresses done
        d0 = done_cnt;
        bus.op = 3'd4; bus.alu_src1 = 32'd9; bus.alu_src2 = 32'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b1;
        #2;
        chk("flush_done_pulse", {31'b0, bus.done}, 32'd0);
        chk("flush_done_result", bus.result, 32'd7);
        tick();
        bus.flush = 1'b0;
        tick();
        chk("flush_done_count", done_cnt - d0, 0);
        $display("flush in DONE: done suppressed, result=%h", bus.result);

        // flush together with start in IDLE drops the request
        bus.op = 3'd5; bus.alu_src1 = 32'd40; bus.alu_src2 = 32'd0;
        bus.start = 1'b1; bus.flush = 1'b1;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("idle_flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("idle_flush_done", {31'b0, bus.done}, 32'd0);
        tick();
        $display("start+flush in IDLE: dropped");

        // second start while busy is ignored
        d0 = done_cnt;
        bus.op = 3'd5; bus.alu_src1 = 32'd100; bus.alu_src2 = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.op = 3'd0; bus.alu_src1 = 32'd3; bus.alu_src2 = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
        chk("busy_start_result", bus.result, 32'd14);
        repeat (40) tick();
        chk("busy_start_pulses", done_cnt - d0, 1);
        $display("start while busy: ignored, result=%h", bus.result);

        // synchronous reset mid-CALC
        bus.op = 3'd4; bus.alu_src1 = 32'd1000; bus.alu_src2 = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_done", {31'b0, bus.done}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        $display("reset mid-CALC: busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
        tick();
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
